// File: rtl/mem_interface_unit_pkg.sv
// Shared types and constants for the memory interface unit.
package mem_interface_unit_pkg;

  localparam int unsigned SIZE_WORD = 16;

  typedef enum logic [1:0] {
    MEMIF_IDLE   = 2'd0,
    MEMIF_ACCESS = 2'd1,
    MEMIF_DONE   = 2'd2
  } memif_state_e;

  localparam logic DST_PC  = 1'b0;
  localparam logic DST_ALU = 1'b1;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam logic [3:0] MEMIF_TIMEOUT_MAX = 4'd15;

  // Request captured at acceptance and held stable for the whole access.
  typedef struct packed {
    logic                 is_write;
    logic                 dst;
    logic [SIZE_WORD-1:0] addr;
    logic [SIZE_WORD-1:0] wdata;
  } memif_req_t;

endpackage

// File: rtl/mem_interface_unit_if.sv
// Memory-side bus of the memory interface unit: strobes, address/data and completion.
interface mem_interface_unit_if;

  logic                                           readM;
  logic                                           writeM;
  logic [mem_interface_unit_pkg::SIZE_WORD-1:0]   address;
  logic [mem_interface_unit_pkg::SIZE_WORD-1:0]   mem_wdata;
  logic [mem_interface_unit_pkg::SIZE_WORD-1:0]   mem_rdata;
  logic                                           inputReady;

  modport master (
    output readM, writeM, address, mem_wdata,
    input  mem_rdata, inputReady
  );

  modport slave (
    input  readM, writeM, address, mem_wdata,
    output mem_rdata, inputReady
  );

endinterface

// File: rtl/memif_watchdog.sv
// Access timeout counter; only built when MEMIF_TIMEOUT_EN is defined.
`ifdef MEMIF_TIMEOUT_EN
module memif_watchdog
  import mem_interface_unit_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  input  logic ready,
  output logic expired
);

  logic [3:0] count_q, count_d;

  // Idle cycles keep the count at zero, so every access starts from a clean count.
  always_comb begin
    count_d = count_q;
    if (!active) begin
      count_d = '0;
    end else if (!ready) begin
      count_d = count_q + 4'd1;
    end
  end

  // Fires on the waiting cycle whose increment would reach the limit.
  assign expired = active && !ready && (count_q == MEMIF_TIMEOUT_MAX - 4'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/mem_interface_unit.sv
// Memory interface unit: single-access IDLE/ACCESS/DONE sequencer for fetch, load and store.
// Optional access timeout enabled by defining MEMIF_TIMEOUT_EN.
module mem_interface_unit
  import mem_interface_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic                 MemDst,
  input  logic [SIZE_WORD-1:0] pc,
  input  logic [SIZE_WORD-1:0] alu_out,
  input  logic [SIZE_WORD-1:0] wdata,
  mem_interface_unit_if.master bus,
  output logic [SIZE_WORD-1:0] inst,
  output logic [SIZE_WORD-1:0] mdr,
  output logic                 mem_done,
  output logic                 mem_err
);

  memif_state_e         state_q, state_d;
  logic                 armed_q, armed_d;
  memif_req_t           req_q, req_d;
  logic [SIZE_WORD-1:0] inst_q, inst_d;
  logic [SIZE_WORD-1:0] mdr_q, mdr_d;
  logic                 err_q, err_d;
  logic                 in_access;
  logic                 timeout;

  assign in_access = (state_q == MEMIF_ACCESS);

`ifdef MEMIF_TIMEOUT_EN
  memif_watchdog u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (in_access),
    .ready   (bus.inputReady),
    .expired (timeout)
  );
`else
  assign timeout = OFF;
`endif

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    req_d   = req_q;
    inst_d  = inst_q;
    mdr_d   = mdr_q;
    err_d   = err_q;

    if (!MemRead && !MemWrite) begin
      armed_d = ON;
    end

    case (state_q)
      MEMIF_IDLE: begin
        if (armed_q && (MemRead || MemWrite)) begin
          req_d.is_write = !MemRead;
          req_d.dst      = MemDst;
          req_d.addr     = (MemDst == DST_ALU) ? alu_out : pc;
          req_d.wdata    = wdata;
          armed_d        = OFF;
          state_d        = MEMIF_ACCESS;
          if (MemRead && MemWrite) begin
            err_d = ON;
          end
        end
      end
      MEMIF_ACCESS: begin
        if (bus.inputReady) begin
          if (!req_q.is_write) begin
            if (req_q.dst == DST_PC) inst_d = bus.mem_rdata;
            else                     mdr_d  = bus.mem_rdata;
          end
          state_d = MEMIF_DONE;
        end else if (timeout) begin
          err_d   = ON;
          state_d = MEMIF_DONE;
        end
      end
      MEMIF_DONE: state_d = MEMIF_IDLE;
      default:    state_d = MEMIF_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= MEMIF_IDLE;
      armed_q <= ON;
      req_q   <= '0;
      inst_q  <= '0;
      mdr_q   <= '0;
      err_q   <= OFF;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      req_q   <= req_d;
      inst_q  <= inst_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode from state, so a reset edge drops them immediately.
  assign bus.readM     = in_access && !req_q.is_write;
  assign bus.writeM    = in_access &&  req_q.is_write;
  assign bus.address   = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign inst          = inst_q;
  assign mdr           = mdr_q;
  assign mem_done      = (state_q == MEMIF_DONE);
  assign mem_err       = err_q;

endmodule
